// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard controller: PC/IF-ID/ID-EX enables for load-use, taken-branch
// redirect, imem latency and dmem freeze, with saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             ifid_flag,
    output logic             ifid_pc_replace,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_REDIRECT   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             load_use;
    logic             load_use_eff;
    logic             stall_inc;
    logic             flush_inc;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // After a load-use stall EX holds the bubble, so the hazard cannot recur.
    assign load_use_eff = load_use && (state_q != ST_LOAD_STALL);

    always_comb begin
        pc_write        = 1'b0;
        ifid_flag       = 1'b0;
        ifid_pc_replace = 1'b0;
        idex_bubble     = 1'b1;
        pipe_freeze     = 1'b0;
        state_d         = state_q;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;
        if (!rst_n) begin
            state_d = ST_RUN;
        end else if (dmem_busy) begin
            idex_bubble = 1'b0;
            pipe_freeze = 1'b1;
            stall_inc   = 1'b1;
            if (state_q != ST_REDIRECT && state_q != ST_LOAD_STALL) begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_REDIRECT) begin
            idex_bubble = 1'b0;
            ifid_flag   = 1'b1;
            if (imem_ready) begin
                pc_write = 1'b1;
                state_d  = ST_RUN;
            end else begin
                ifid_pc_replace = 1'b1;
                stall_inc       = 1'b1;
            end
        end else if (ex_branch_taken) begin
            pc_write        = 1'b1;
            ifid_flag       = 1'b1;
            ifid_pc_replace = 1'b1;
            state_d         = ST_REDIRECT;
            flush_inc       = 1'b1;
        end else if (load_use_eff) begin
            state_d   = ST_LOAD_STALL;
            stall_inc = 1'b1;
        end else if (!imem_ready) begin
            ifid_flag       = 1'b1;
            ifid_pc_replace = 1'b1;
            idex_bubble     = 1'b0;
            stall_inc       = 1'b1;
            state_d         = ST_RUN;
        end else begin
            pc_write    = 1'b1;
            ifid_flag   = 1'b1;
            idex_bubble = 1'b0;
            state_d     = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc && stall_q != CNT_MAX) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_inc && flush_q != CNT_MAX) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign state       = state_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule
